// File: rtl/alu_sequencer.sv
// alu_sequencer: command-level controller for the ALU datapath.
// Walks one ALU instruction over a run of output blocks, issuing
// read-buffer fill, a single-cycle ALU execute and write-back per block,
// with multiple passes per block for pool and dot-product ops.
module alu_sequencer #(
  parameter int unsigned DOT_STEPS = 4,
  parameter int unsigned IDX_W     = 16
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_rev_mask,
  input  logic [IDX_W-1:0] cmd_count,
  output logic             rd_req,
  output logic [IDX_W-1:0] rd_idx,
  input  logic             rd_valid,
  output logic             alu_execute,
  output logic [2:0]       alu_op,
  output logic             alu_rev_mask,
  output logic [1:0]       alu_sub_block,
  output logic [3:0]       alu_sub_index,
  input  logic             alu_done,
  output logic             wb_req,
  output logic [IDX_W-1:0] wb_idx,
  input  logic             wb_ack,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_WRITE,
    S_FIN
  } state_e;

  localparam logic [2:0] OP_FPOOL = 3'b001;
  localparam logic [2:0] OP_BPOOL = 3'b010;
  localparam logic [2:0] OP_DOT   = 3'b101;
  localparam logic [3:0] POOL_LAST = 4'd3;
  localparam logic [3:0] DOT_LAST  = 4'(DOT_STEPS - 1);

  state_e state_q, state_d;

  logic [2:0]       op_q, op_d;
  logic             rev_q, rev_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [3:0]       pass_q, pass_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] wb_idx_q, wb_idx_d;
  logic             err_q, err_d;
  logic [1:0]       sub_block_q, sub_block_d;
  logic [3:0]       sub_index_q, sub_index_d;

  logic             cmd_illegal;
  logic [3:0]       pass_last;
  logic             last_pass;
  logic             last_block;

  // Decode of the incoming opcode and of the latched command's pass count
  always_comb begin
    cmd_illegal = cmd_op[2] & cmd_op[1];
    pass_last   = '0;
    if ((op_q == OP_FPOOL) || (op_q == OP_BPOOL)) begin
      pass_last = POOL_LAST;
    end else if (op_q == OP_DOT) begin
      pass_last = DOT_LAST;
    end
    last_pass  = (pass_q == pass_last);
    last_block = (wb_idx_q == (count_q - IDX_W'(1)));
  end

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; each handshake input is only looked at in its own state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_illegal || (cmd_count == '0)) begin
            state_d = S_FIN;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: if (rd_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_WAIT;
      S_WAIT: begin
        if (alu_done) state_d = last_pass ? S_WRITE : S_FETCH;
      end
      S_WRITE: begin
        if (wb_ack) state_d = last_block ? S_FIN : S_FETCH;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the command latch, pass counter and block indices
  always_comb begin
    op_d     = op_q;
    rev_d    = rev_q;
    count_d  = count_q;
    pass_d   = pass_q;
    rd_idx_d = rd_idx_q;
    wb_idx_d = wb_idx_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          rev_d    = cmd_rev_mask;
          count_d  = cmd_count;
          err_d    = cmd_illegal;
          pass_d   = '0;
          rd_idx_d = '0;
          wb_idx_d = '0;
        end
      end
      S_WAIT: begin
        if (alu_done && !last_pass) begin
          pass_d   = pass_q + 4'd1;
          rd_idx_d = rd_idx_q + IDX_W'(1);
        end
      end
      S_WRITE: begin
        if (wb_ack && !last_block) begin
          pass_d   = '0;
          wb_idx_d = wb_idx_q + IDX_W'(1);
          rd_idx_d = rd_idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
    // Pass number is steered to whichever field the op uses; the other stays 0
    sub_block_d = ((op_d == OP_FPOOL) || (op_d == OP_BPOOL)) ? pass_d[1:0] : '0;
    sub_index_d = (op_d == OP_DOT) ? pass_d : '0;
  end

  // Datapath registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      op_q        <= '0;
      rev_q       <= 1'b0;
      count_q     <= '0;
      pass_q      <= '0;
      rd_idx_q    <= '0;
      wb_idx_q    <= '0;
      err_q       <= 1'b0;
      sub_block_q <= '0;
      sub_index_q <= '0;
    end else begin
      op_q        <= op_d;
      rev_q       <= rev_d;
      count_q     <= count_d;
      pass_q      <= pass_d;
      rd_idx_q    <= rd_idx_d;
      wb_idx_q    <= wb_idx_d;
      err_q       <= err_d;
      sub_block_q <= sub_block_d;
      sub_index_q <= sub_index_d;
    end
  end

  // Outputs decoded from the current state and the registered datapath
  always_comb begin
    cmd_ready     = (state_q == S_IDLE);
    busy          = (state_q != S_IDLE);
    rd_req        = (state_q == S_FETCH);
    alu_execute   = (state_q == S_EXEC);
    wb_req        = (state_q == S_WRITE);
    done          = (state_q == S_FIN);
    err           = err_q;
    rd_idx        = rd_idx_q;
    wb_idx        = wb_idx_q;
    alu_op        = op_q;
    alu_rev_mask  = rev_q;
    alu_sub_block = sub_block_q;
    alu_sub_index = sub_index_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: table of directed commands, a hand-written
// reset-abort sequence, then randomized commands against a behavioural model.
module tb_alu_sequencer;

  localparam int unsigned DOT = 4;
  localparam int unsigned IW  = 16;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic          cmd_rev_mask = 1'b0;
  logic [IW-1:0] cmd_count = '0;
  logic          rd_req;
  logic [IW-1:0] rd_idx;
  logic          rd_valid = 1'b0;
  logic          alu_execute;
  logic [2:0]    alu_op;
  logic          alu_rev_mask;
  logic [1:0]    alu_sub_block;
  logic [3:0]    alu_sub_index;
  logic          alu_done = 1'b0;
  logic          wb_req;
  logic [IW-1:0] wb_idx;
  logic          wb_ack = 1'b0;
  logic          busy;
  logic          done;
  logic          err;

  alu_sequencer #(.DOT_STEPS(DOT), .IDX_W(IW)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rev_mask(cmd_rev_mask), .cmd_count(cmd_count),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid),
    .alu_execute(alu_execute), .alu_op(alu_op), .alu_rev_mask(alu_rev_mask),
    .alu_sub_block(alu_sub_block), .alu_sub_index(alu_sub_index), .alu_done(alu_done),
    .wb_req(wb_req), .wb_idx(wb_idx), .wb_ack(wb_ack),
    .busy(busy), .done(done), .err(err)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [2:0]    op;
    logic          rev;
    logic [1:0]    sb;
    logic [3:0]    si;
    logic [IW-1:0] ri;
    logic [IW-1:0] wi;
  } exec_t;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        rev;
    int unsigned cnt;
    int unsigned rd_dly;
    int unsigned alu_dly;
    int unsigned wb_dly;
    bit          noise;
    int          exp_done;
    int          exp_err;
    int          exp_ex;
  } vec_t;

  exec_t         got_ex[$];
  logic [IW-1:0] got_wb[$];
  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full visible output state, used for reset checks
  function automatic logic [63:0] outs();
    return 64'({cmd_ready, busy, rd_req, alu_execute, wb_req, done, err,
                alu_op, alu_rev_mask, alu_sub_block, alu_sub_index, rd_idx, wb_idx});
  endfunction

  localparam logic [63:0] RESET_OUTS = 64'(49'h1 << 48);

  // Issue one command from a negedge and act as the read/ALU/write responders.
  // Returns at the negedge where done is seen (or on budget expiry).
  task automatic run_cmd(input logic [2:0] op, input logic rev, input int unsigned cnt,
                         input int unsigned rd_dly, input int unsigned alu_dly,
                         input int unsigned wb_dly, input bit noise,
                         output int done_cyc, output int unsigned rdreq_cyc,
                         output logic err1, output logic ready1, output logic errd,
                         output int unsigned bad_busy);
    int unsigned cyc, fw, wk, ak;
    bit pend, fin, wait_vis;
    exec_t e;
    got_ex.delete();
    got_wb.delete();
    done_cyc = -1; rdreq_cyc = 0; err1 = 1'bx; ready1 = 1'bx; errd = 1'bx; bad_busy = 0;
    cyc = 0;
    while (!cmd_ready && cyc < 100) begin
      @(negedge iCLK);
      cyc++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_rev_mask = rev; cmd_count = IW'(cnt);
    rd_valid = 1'b0; alu_done = 1'b0; wb_ack = 1'b0;
    fw = 0; wk = 0; ak = 0; pend = 1'b0; fin = 1'b0; cyc = 0;
    while (!fin && cyc < 5000) begin
      @(negedge iCLK);
      cyc++;
      if (noise) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op = 3'($urandom); cmd_rev_mask = 1'($urandom); cmd_count = IW'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      if (cyc == 1) begin
        err1 = err;
        ready1 = cmd_ready;
      end
      if (busy === cmd_ready) bad_busy++;
      wait_vis = busy && !rd_req && !alu_execute && !wb_req && !done;
      if (alu_execute) begin
        e.op = alu_op; e.rev = alu_rev_mask; e.sb = alu_sub_block;
        e.si = alu_sub_index; e.ri = rd_idx; e.wi = wb_idx;
        got_ex.push_back(e);
      end
      // read buffer responder
      if (rd_req) begin
        rdreq_cyc++;
        rd_valid = (fw >= rd_dly);
        fw++;
      end else begin
        fw = 0;
        rd_valid = noise && ($urandom_range(0, 3) == 0);
      end
      // ALU responder; a done during EXEC must be ignored
      if (alu_execute) begin
        pend = 1'b1; ak = 0;
        alu_done = noise;
      end else if (pend) begin
        alu_done = (ak >= alu_dly);
        if (alu_done) pend = 1'b0;
        ak++;
      end else begin
        alu_done = noise && !wait_vis && ($urandom_range(0, 3) == 0);
      end
      // write-back responder
      if (wb_req) begin
        wb_ack = (wk >= wb_dly);
        if (wb_ack) got_wb.push_back(wb_idx);
        wk++;
      end else begin
        wk = 0;
        wb_ack = noise && ($urandom_range(0, 3) == 0);
      end
      if (done) begin
        done_cyc = int'(cyc);
        errd = err;
        fin = 1'b1;
        cmd_valid = 1'b0;
      end
    end
    if (!fin) check("done_timeout", 64'd1, 64'd0);
  endtask

  // Run one command and compare everything against the reference model;
  // table constants (>=0) are compared in addition.
  task automatic verify(input string tag, input logic [2:0] op, input logic rev,
                        input int unsigned cnt, input int unsigned rd_dly,
                        input int unsigned alu_dly, input int unsigned wb_dly,
                        input bit noise, input int t_done, input int t_err, input int t_ex);
    int d; int unsigned rq, bb, p_n, nex, exp_d, nwb;
    logic e1, r1, ed;
    bit legal, pool, dot;
    exec_t x;
    run_cmd(op, rev, cnt, rd_dly, alu_dly, wb_dly, noise, d, rq, e1, r1, ed, bb);
    legal = (op <= 3'd5);
    pool  = (op == 3'd1) || (op == 3'd2);
    dot   = (op == 3'd5);
    p_n   = pool ? 4 : (dot ? DOT : 1);
    nex   = (legal && cnt != 0) ? cnt * p_n : 0;
    nwb   = (legal && cnt != 0) ? cnt : 0;
    exp_d = (nex != 0) ? 1 + cnt * (p_n * (rd_dly + alu_dly + 3) + wb_dly + 1) : 1;
    check({tag, "_done_cycle"}, 64'(d), 64'(exp_d));
    if (t_done >= 0) check({tag, "_done_cycle_tbl"}, 64'(d), 64'(t_done));
    if (t_err >= 0)  check({tag, "_err_tbl"}, 64'(ed), 64'(t_err));
    if (t_ex >= 0)   check({tag, "_nexec_tbl"}, 64'(got_ex.size()), 64'(t_ex));
    check({tag, "_err_after_accept"}, 64'(e1), 64'(!legal));
    check({tag, "_err_at_done"}, 64'(ed), 64'(!legal));
    check({tag, "_ready_after_accept"}, 64'(r1), 64'd0);
    check({tag, "_busy_vs_ready"}, 64'(bb), 64'd0);
    check({tag, "_rdreq_cycles"}, 64'(rq), 64'(nex * (rd_dly + 1)));
    check({tag, "_nexec"}, 64'(got_ex.size()), 64'(nex));
    check({tag, "_nwb"}, 64'(got_wb.size()), 64'(nwb));
    for (int unsigned i = 0; i < nex && i < got_ex.size(); i++) begin
      x.op  = op;
      x.rev = rev;
      x.sb  = pool ? 2'(i % p_n) : 2'd0;
      x.si  = dot ? 4'(i % p_n) : 4'd0;
      x.ri  = IW'(i);
      x.wi  = IW'(i / p_n);
      check($sformatf("%s_exec%0d", tag, i), 64'(got_ex[i]), 64'(x));
    end
    for (int unsigned i = 0; i < nwb && i < got_wb.size(); i++) begin
      check($sformatf("%s_wb%0d", tag, i), 64'(got_wb[i]), 64'(i));
    end
  endtask

  vec_t tbl[$];

  initial begin
    int unsigned nwait;
    bit hit;
    tbl.push_back('{"relu3",     3'b011, 1'b0, 3, 0, 0, 0, 1'b0, 13, 0, 3});
    tbl.push_back('{"fpool2",    3'b001, 1'b0, 2, 0, 0, 0, 1'b0, 27, 0, 8});
    tbl.push_back('{"dot_slow",  3'b101, 1'b0, 1, 5, 7, 0, 1'b1, 62, 0, 4});
    tbl.push_back('{"illegal7",  3'b111, 1'b0, 3, 0, 0, 0, 1'b0,  1, 1, 0});
    tbl.push_back('{"conv_cnt0", 3'b000, 1'b1, 0, 0, 0, 0, 1'b0,  1, 0, 0});
    tbl.push_back('{"bpool1",    3'b010, 1'b1, 1, 1, 2, 1, 1'b1, 27, 0, 4});
    tbl.push_back('{"illegal6",  3'b110, 1'b1, 5, 0, 0, 0, 1'b1,  1, 1, 0});
    tbl.push_back('{"diff2",     3'b100, 1'b0, 2, 2, 0, 3, 1'b1, 19, 0, 2});
    tbl.push_back('{"conv4",     3'b000, 1'b1, 4, 0, 0, 0, 1'b0, 17, 0, 4});

    // Reset state
    iRST_N = 1'b0;
    repeat (2) @(negedge iCLK);
    check("reset_outputs", outs(), RESET_OUTS);
    iRST_N = 1'b1;
    @(negedge iCLK);

    foreach (tbl[i]) begin
      verify(tbl[i].name, tbl[i].op, tbl[i].rev, tbl[i].cnt, tbl[i].rd_dly,
             tbl[i].alu_dly, tbl[i].wb_dly, tbl[i].noise,
             tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_ex);
    end

    // err is sticky in IDLE, and reset clears it asynchronously
    verify("illegal_sticky", 3'b111, 1'b0, 1, 0, 0, 0, 1'b0, 1, 1, 0);
    @(negedge iCLK);
    check("err_sticky_idle", 64'(err), 64'd1);
    #2 iRST_N = 1'b0;
    #1 check("err_cleared_by_reset", 64'(err), 64'd0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);

    // Reset during WAIT of the second block of a 3-block conv
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_rev_mask = 1'b1; cmd_count = IW'(3);
    rd_valid = 1'b1; wb_ack = 1'b1; alu_done = 1'b0;
    nwait = 0; hit = 1'b0;
    for (int unsigned c = 0; c < 60 && !hit; c++) begin
      @(negedge iCLK);
      cmd_valid = 1'b0;
      if (busy && !rd_req && !alu_execute && !wb_req && !done) begin
        nwait++;
        if (nwait == 2) hit = 1'b1;
        alu_done = 1'b1;
      end else begin
        alu_done = 1'b0;
      end
    end
    check("reach_wait_block1", 64'(hit), 64'd1);
    check("pre_reset_rd_idx", 64'(rd_idx), 64'd1);
    #2 iRST_N = 1'b0;
    #1 check("abort_outputs", outs(), RESET_OUTS);
    alu_done = 1'b1;
    hit = 1'b0;
    repeat (3) begin
      @(negedge iCLK);
      if (done || wb_req) hit = 1'b1;
    end
    check("abort_no_done_or_wb", 64'(hit), 64'd0);
    rd_valid = 1'b0; wb_ack = 1'b0; alu_done = 1'b0;
    iRST_N = 1'b1;
    @(negedge iCLK);
    verify("after_abort", 3'b000, 1'b0, 2, 0, 0, 0, 1'b0, 9, 0, 2);

    // Randomized commands against the model
    for (int n = 0; n < 40; n++) begin
      verify($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), 1'($urandom),
             $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), 1'b1, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-level controller for the ALU datapath. It accepts one ALU instruction covering a run of blocks. For each block it sequences read-buffer fill, ALU execute, and write-back. It also drives the per-pass flags: `sub_block` for the pool operations and `sub_index` for the dot product. It sits between the top-level layer scheduler and the ALU / READ_BUFFER / WRITE_BACK interfaces, and is the only agent that asserts ALU execute.

## Interface
- `DOT_STEPS`, default 4: passes per output block for the dot-product op (≥1, ≤16).
- `IDX_W`, default 16: width of the block count and block indices.
- `iCLK` in 1: clock; all logic is rising-edge.
- `iRST_N` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the sequencer is idle and can accept a command.
- `cmd_op` in 3: opcode. 000 conv, 001 fwd pool, 010 bwd pool, 011 ReLU, 100 difference, 101 dot product; 110/111 are illegal.
- `cmd_rev_mask` in 1: convolution mask-reverse flag.
- `cmd_count` in `IDX_W`: number of output blocks.
- `rd_req` out 1: request that the read buffers and mask be loaded for `rd_idx`.
- `rd_idx` out `IDX_W`: input block index, counted from 0 per command.
- `rd_valid` in 1: the buffers for `rd_idx` are loaded.
- `alu_execute` out 1: one-cycle start pulse to the ALU.
- `alu_op` out 3: latched opcode.
- `alu_rev_mask` out 1: latched flag.
- `alu_sub_block` out 2: pool pass number.
- `alu_sub_index` out 4: dot-product pass number.
- `alu_done` in 1: the ALU has finished the current pass.
- `wb_req` out 1: write back output block `wb_idx`.
- `wb_idx` out `IDX_W`: output block index.
- `wb_ack` in 1: write-back accepted.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at command completion.
- `err` out 1: sticky illegal-opcode flag, cleared when the next command is accepted.

## Operation
- Passes per output block, P:
  - 4 for 001/010, with `alu_sub_block` = pass.
  - `DOT_STEPS` for 101, with `alu_sub_index` = pass.
  - 1 otherwise; the pass fields are then held at 0.
- Each pass consumes one fresh input block, so `rd_idx` increments every pass. Write-back happens once per output block, after its last pass.
- States: IDLE, FETCH, EXEC, WAIT, WRITE, FIN.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch op, rev_mask and count, clear `err`, and zero pass, `rd_idx` and `wb_idx`.
  - Illegal op: set `err`, go to FIN.
  - `cmd_count`=0: go to FIN.
  - Otherwise go to FETCH.
- FETCH: `rd_req`=1 until `rd_valid` is sampled high, then go to EXEC.
- EXEC: `alu_execute`=1 for exactly one cycle, then go to WAIT.
- WAIT: hold until `alu_done`.
  - If pass < P−1: pass+1, `rd_idx`+1, go to FETCH.
  - Else go to WRITE.
- WRITE: `wb_req`=1 until `wb_ack`.
  - If `wb_idx` = count−1: go to FIN.
  - Else: `wb_idx`+1, `rd_idx`+1, pass=0, go to FETCH.
- FIN: `done`=1 for one cycle, then go to IDLE.
- `alu_op`, `alu_rev_mask`, `alu_sub_block` and `alu_sub_index` are registered. They are stable from the EXEC cycle through `alu_done`.
- Input sampling by state:
  - `rd_valid` only in FETCH.
  - `alu_done` only in WAIT; an `alu_done` during the EXEC cycle is ignored.
  - `wb_ack` only in WRITE.
  - `cmd_valid` outside IDLE is ignored.

## Timing
- Reset value of every output is 0, except `cmd_ready`=1; state resets to IDLE.
- Reset asserted mid-command aborts immediately: no `done` and no write-back, and `err` is cleared.
- Accept cycle → `rd_req` high the next cycle.
- With zero-wait responders (`rd_valid`, `alu_done`, `wb_ack` each high on the first eligible cycle), a single-pass block costs 4 cycles: FETCH, EXEC, WAIT, WRITE.
  - An N-block command: accept at cycle 0, `done` at cycle 4N+1.
  - A 4-pass block costs 13 cycles.
- Count 0 or illegal op: accept at cycle 0, `done` at cycle 1, with no `rd_req`, `alu_execute` or `wb_req`.
- `cmd_ready` deasserts on the cycle after accept and reasserts the cycle after `done`.
- A back-to-back command can be accepted the cycle after `done`.
- `rd_idx` / `wb_idx` wrap modulo 2^`IDX_W`. This never occurs for a legal count on single-pass ops.

## Test plan
- Single-pass ReLU: op=011, count=3, zero-wait responders:
  - 3 `alu_execute` pulses with `rd_idx` 0,1,2 and `wb_idx` 0,1,2.
  - `done` at cycle 13; `alu_sub_block`=0 throughout.
- Forward pool: op=001, count=2:
  - 8 executes with `alu_sub_block` 0,1,2,3,0,1,2,3 and `rd_idx` 0..7.
  - `wb_req` only after sub_block 3, with `wb_idx` 0 then 1.
- Dot product: op=101, `DOT_STEPS`=4, with `rd_valid` delayed 5 cycles and `alu_done` delayed 7 cycles per pass:
  - `rd_req` is held until `rd_valid`; exactly one execute per pass.
  - `alu_sub_index` 0..3; spurious `alu_done` during EXEC is ignored.
- Illegal op 111:
  - `err`=1, `done` at cycle 1, no bus activity.
  - The next legal command clears `err` on its accept cycle.
- Count 0 with op=000, rev_mask=1: `done` at cycle 1 and no execute.
- Reset mid-WAIT of a 3-block conv (`iRST_N` low asynchronously):
  - All outputs 0 and `cmd_ready`=1 before the next clock edge; no `done`.
  - A new command after release runs from `rd_idx`=0.
